// File: rtl/carfield_addrmap_responder.sv
// carfield_addrmap_responder
//
// Register-bus responder exposing the SoC address map (per-entry enable,
// base, size) to software, plus a lookup engine that finds which entry
// decodes a 64-bit query address.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   entry_en_i          per-entry enable strap
//   entry_base_i        per-entry 64-bit base, entry i at [64*i +: 64]
//   entry_size_i        per-entry 64-bit size in bytes
//   req_valid_i ..      regbus request (write, addr, wdata, wstrb)
//   req_ready_o         request accepted; response valid this cycle
//   rsp_rdata_o         read data (registered)
//   rsp_error_o         error flag (registered)
//   busy_o              lookup engine scanning
//
// Optional feature macro: CARFIELD_ADDRMAP_OVERLAP_CHECK_EN
//   defined   -> full scan every time, lowest matching index, multi-hit flag
//   undefined -> scan stops on the first hit, STATUS.multi reads 0
module carfield_addrmap_responder #(
  parameter int unsigned NumEntries = 16,
  parameter int unsigned AddrWidth  = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumEntries-1:0]    entry_en_i,
  input  logic [NumEntries*64-1:0] entry_base_i,
  input  logic [NumEntries*64-1:0] entry_size_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [AddrWidth-1:0]     req_addr_i,
  input  logic [31:0]              req_wdata_i,
  input  logic [3:0]               req_wstrb_i,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_error_o,
  output logic                     busy_o
);

  localparam int unsigned SelW = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam logic [SelW-1:0] LastIdx = SelW'(NumEntries - 1);

  localparam logic [AddrWidth-1:0] OffInfo   = AddrWidth'(32'h00);
  localparam logic [AddrWidth-1:0] OffSel    = AddrWidth'(32'h04);
  localparam logic [AddrWidth-1:0] OffBaseLo = AddrWidth'(32'h08);
  localparam logic [AddrWidth-1:0] OffBaseHi = AddrWidth'(32'h0C);
  localparam logic [AddrWidth-1:0] OffSizeLo = AddrWidth'(32'h10);
  localparam logic [AddrWidth-1:0] OffSizeHi = AddrWidth'(32'h14);
  localparam logic [AddrWidth-1:0] OffEn     = AddrWidth'(32'h18);
  localparam logic [AddrWidth-1:0] OffQLo    = AddrWidth'(32'h20);
  localparam logic [AddrWidth-1:0] OffQHi    = AddrWidth'(32'h24);
  localparam logic [AddrWidth-1:0] OffCtrl   = AddrWidth'(32'h28);
  localparam logic [AddrWidth-1:0] OffStatus = AddrWidth'(32'h2C);

  typedef enum logic {StIdle = 1'b0, StScan = 1'b1} state_e;

  // Byte-lane merge of a write into an existing 32-bit value.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // Region hit test; the end address is formed in 65 bits so a region
  // touching the top of the 64-bit space does not wrap.
  function automatic logic entry_match(input logic        en,
                                       input logic [63:0] base,
                                       input logic [63:0] size,
                                       input logic [63:0] q);
    logic [64:0] w_end;
    w_end = {1'b0, base} + {1'b0, size};
    return en && (size != 64'h0) && (q >= base) && ({1'b0, q} < w_end);
  endfunction

  state_e          r_state, w_state_nxt;
  logic [SelW-1:0] r_idx, r_sel, r_hit_idx;
  logic [63:0]     r_qaddr;
  logic            r_done, r_hit, r_multi;
  logic            r_ready, r_error;
  logic [31:0]     r_rdata;

  logic [63:0]     w_base [NumEntries];
  logic [63:0]     w_size [NumEntries];
  logic            w_accept, w_err, w_wr_sel, w_wr_qlo, w_wr_qhi, w_start, w_go;
  logic [31:0]     w_rdata, w_sel_merged, w_status;
  logic            w_busy, w_match, w_last, w_scan_done;

  // A request is taken in the cycle valid is seen while no response is out.
  assign w_accept     = req_valid_i & ~r_ready;
  assign w_busy       = (r_state == StScan);
  assign w_go         = w_accept & w_start;
  assign w_sel_merged = apply_wstrb(32'(r_sel), req_wdata_i, req_wstrb_i);
  assign w_status     = {16'h0000, 8'(r_hit_idx), 4'h0, r_multi, r_hit, r_done, w_busy};

  // Unpack the flat strap vectors into per-entry views.
  always_comb begin
    for (int i = 0; i < NumEntries; i++) begin
      w_base[i] = entry_base_i[64*i +: 64];
      w_size[i] = entry_size_i[64*i +: 64];
    end
  end

  // Register decode: read mux, error detection and write enables.
  always_comb begin
    w_rdata  = 32'h0000_0000;
    w_err    = 1'b0;
    w_wr_sel = 1'b0;
    w_wr_qlo = 1'b0;
    w_wr_qhi = 1'b0;
    w_start  = 1'b0;
    case (req_addr_i)
      OffInfo: begin
        if (req_write_i) w_err = 1'b1;
        else             w_rdata = {16'hCAF1, 8'h00, 8'(NumEntries - 1)};
      end
      OffSel: begin
        if (req_write_i) begin
          if (w_sel_merged >= 32'(NumEntries)) w_err = 1'b1;
          else                                 w_wr_sel = 1'b1;
        end else begin
          w_rdata = 32'(r_sel);
        end
      end
      OffBaseLo: begin
        if (req_write_i) w_err = 1'b1;
        else             w_rdata = w_base[r_sel][31:0];
      end
      OffBaseHi: begin
        if (req_write_i) w_err = 1'b1;
        else             w_rdata = w_base[r_sel][63:32];
      end
      OffSizeLo: begin
        if (req_write_i) w_err = 1'b1;
        else             w_rdata = w_size[r_sel][31:0];
      end
      OffSizeHi: begin
        if (req_write_i) w_err = 1'b1;
        else             w_rdata = w_size[r_sel][63:32];
      end
      OffEn: begin
        if (req_write_i) w_err = 1'b1;
        else             w_rdata = {31'h0, entry_en_i[r_sel]};
      end
      OffQLo: begin
        if (req_write_i) begin
          if (w_busy) w_err = 1'b1;
          else        w_wr_qlo = 1'b1;
        end else begin
          w_rdata = r_qaddr[31:0];
        end
      end
      OffQHi: begin
        if (req_write_i) begin
          if (w_busy) w_err = 1'b1;
          else        w_wr_qhi = 1'b1;
        end else begin
          w_rdata = r_qaddr[63:32];
        end
      end
      OffCtrl: begin
        // Write-only: reads return zero without error.
        if (req_write_i) begin
          if (w_busy) w_err = 1'b1;
          else        w_start = req_wstrb_i[0] & req_wdata_i[0];
        end else begin
          w_rdata = 32'h0000_0000;
        end
      end
      OffStatus: begin
        if (req_write_i) w_err = 1'b1;
        else             w_rdata = w_status;
      end
      default: w_err = 1'b1;
    endcase
  end

  // Scan datapath: test the entry under the cursor.
  always_comb begin
    w_match = entry_match(entry_en_i[r_idx], w_base[r_idx], w_size[r_idx], r_qaddr);
    w_last  = (r_idx == LastIdx);
`ifdef CARFIELD_ADDRMAP_OVERLAP_CHECK_EN
    w_scan_done = w_last;
`else
    w_scan_done = w_match | w_last;
`endif
  end

  // Lookup FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_go) w_state_nxt = StScan;
        else      w_state_nxt = StIdle;
      end
      StScan: begin
        if (w_scan_done) w_state_nxt = StIdle;
        else             w_state_nxt = StScan;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Lookup FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Scan cursor and result flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_hit     <= 1'b0;
      r_multi   <= 1'b0;
      r_hit_idx <= '0;
    end else if (w_go) begin
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_hit     <= 1'b0;
      r_multi   <= 1'b0;
      r_hit_idx <= '0;
    end else if (w_busy) begin
      r_idx  <= r_idx + SelW'(1);
      r_done <= w_scan_done;
`ifdef CARFIELD_ADDRMAP_OVERLAP_CHECK_EN
      // Keep the lowest matching index; any later match flags an overlap.
      if (w_match) begin
        if (!r_hit) begin
          r_hit     <= 1'b1;
          r_hit_idx <= r_idx;
        end else begin
          r_multi <= 1'b1;
        end
      end
`else
      if (w_match) begin
        r_hit     <= 1'b1;
        r_hit_idx <= r_idx;
      end
`endif
    end
  end

  // Software-writable registers: SEL and the query address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel   <= '0;
      r_qaddr <= 64'h0;
    end else if (w_accept) begin
      if (w_wr_sel) r_sel <= w_sel_merged[SelW-1:0];
      if (w_wr_qlo) r_qaddr[31:0]  <= apply_wstrb(r_qaddr[31:0], req_wdata_i, req_wstrb_i);
      if (w_wr_qhi) r_qaddr[63:32] <= apply_wstrb(r_qaddr[63:32], req_wdata_i, req_wstrb_i);
    end
  end

  // Registered bus response, one cycle after the request is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0000_0000;
      r_error <= 1'b0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= w_accept ? w_rdata : 32'h0000_0000;
      r_error <= w_accept & w_err;
    end
  end

  assign req_ready_o = r_ready;
  assign rsp_rdata_o = r_rdata;
  assign rsp_error_o = r_error;
  assign busy_o      = w_busy;

endmodule
